// File: rtl/rf_wb_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter:
// default widths, the r0 constant and the LLU result FIFO entry.
package rf_wb_arbiter_pkg;

    localparam int RF_AW     = 5;
    localparam int RF_DW     = 32;
    localparam int RF_DEPTH  = 4;

    localparam logic [RF_AW-1:0] REG_ZERO = '0;

    // One queued LLU result: destination register and data.
    typedef struct packed {
        logic [RF_AW-1:0] rd;
        logic [RF_DW-1:0] data;
    } llu_entry_t;

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Bus bundle between the pipeline/LLU/hazard unit and the write-port arbiter.
//
// LLU result handshake: the LLU raises llu_res_valid with llu_res_rd and
// llu_res_data; a transfer happens on a posedge where llu_res_valid and
// llu_res_ready are both 1. While valid is high and ready is low the LLU
// holds valid, rd and data stable. Ready never looks at valid.
interface rf_wb_arbiter_if
    import rf_wb_arbiter_pkg::*;
#(
    parameter int AW = RF_AW,
    parameter int DW = RF_DW
);
    logic          wb_valid;
    logic [AW-1:0] wb_rd;
    logic [DW-1:0] wb_data;
    logic          llu_issue_valid;
    logic [AW-1:0] llu_issue_rd;
    logic          llu_res_valid;
    logic          llu_res_ready;
    logic [AW-1:0] llu_res_rd;
    logic [DW-1:0] llu_res_data;
    logic [AW-1:0] q_rs1;
    logic [AW-1:0] q_rs2;
    logic [AW-1:0] q_rd;
    logic          busy_rs1;
    logic          busy_rs2;
    logic          busy_rd;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic          issue_err;

    modport slave (
        input  wb_valid, wb_rd, wb_data,
        input  llu_issue_valid, llu_issue_rd,
        input  llu_res_valid, llu_res_rd, llu_res_data,
        output llu_res_ready,
        input  q_rs1, q_rs2, q_rd,
        output busy_rs1, busy_rs2, busy_rd,
        output rf_we, rf_waddr, rf_wdata,
        output issue_err
    );

    modport master (
        output wb_valid, wb_rd, wb_data,
        output llu_issue_valid, llu_issue_rd,
        output llu_res_valid, llu_res_rd, llu_res_data,
        input  llu_res_ready,
        output q_rs1, q_rs2, q_rd,
        input  busy_rs1, busy_rs2, busy_rd,
        input  rf_we, rf_waddr, rf_wdata,
        input  issue_err
    );

endinterface

// File: rtl/rf_wb_fifo.sv
// Synchronous DEPTH-entry FIFO for LLU results. The caller guarantees it
// never pushes when full and never pops when empty. Pointers wrap
// naturally because DEPTH is a power of two.
module rf_wb_fifo
    import rf_wb_arbiter_pkg::*;
#(
    parameter int DEPTH = RF_DEPTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  llu_entry_t                 push_entry,
    input  logic                       pop,
    output llu_entry_t                 head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty
);
    localparam int PW = $clog2(DEPTH);

    llu_entry_t      mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;

    // Storage array: written at the tail, contents need no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // Pointer and occupancy bookkeeping; push+pop together keeps count.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter. Pipeline writeback always wins the
// port; LLU results queue in rf_wb_fifo and drain into idle slots. A
// pending scoreboard tracks issued LLU destinations for the hazard unit.
// Optional build macro: LLU_BYPASS_EN lets an LLU result go straight to
// the register file when the port is idle and the FIFO is empty.
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int DEPTH = RF_DEPTH,
    parameter int AW    = RF_AW,   // must match the package entry width
    parameter int DW    = RF_DW    // must match the package entry width
) (
    input  logic          clk,
    input  logic          reset,
    rf_wb_arbiter_if.slave bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [CW-1:0]     count;
    logic              empty;
    llu_entry_t        head;
    llu_entry_t        push_entry;
    logic              xfer;
    logic              push;
    logic              pop;
    logic              bypass;
    logic              llu_wr;
    logic [AW-1:0]     llu_wr_rd;
    logic [2**AW-1:0]  pending;
    logic              issue_err_q;

    // Ready is held high during reset and otherwise depends only on the
    // registered occupancy, never on a same-cycle pop.
    assign bus.llu_res_ready = reset || (count < CW'(DEPTH));
    assign xfer = bus.llu_res_valid && bus.llu_res_ready;

    // The FIFO drains only in cycles the pipeline leaves idle.
    assign pop = !reset && !bus.wb_valid && !empty;

`ifdef LLU_BYPASS_EN
    assign bypass = !reset && !bus.wb_valid && empty && xfer;
`else
    assign bypass = 1'b0;
`endif

    assign push       = !reset && xfer && !bypass;
    assign push_entry = '{rd: bus.llu_res_rd, data: bus.llu_res_data};

    rf_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .count      (count),
        .empty      (empty)
    );

    // Write-port mux: pipeline, then FIFO head, then bypass, else idle.
    always_comb begin
        bus.rf_we    = 1'b0;
        bus.rf_waddr = '0;
        bus.rf_wdata = '0;
        if (bus.wb_valid) begin
            bus.rf_we    = (bus.wb_rd != REG_ZERO);
            bus.rf_waddr = bus.wb_rd;
            bus.rf_wdata = bus.wb_data;
        end else if (pop) begin
            bus.rf_we    = (head.rd != REG_ZERO);
            bus.rf_waddr = head.rd;
            bus.rf_wdata = head.data;
        end else if (bypass) begin
            bus.rf_we    = (bus.llu_res_rd != REG_ZERO);
            bus.rf_waddr = bus.llu_res_rd;
            bus.rf_wdata = bus.llu_res_data;
        end
    end

    assign llu_wr    = pop || bypass;
    assign llu_wr_rd = pop ? head.rd : bus.llu_res_rd;

    // Scoreboard: LLU writes clear, issues set (set wins), re-issue to a
    // pending register raises the sticky error.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending     <= '0;
            issue_err_q <= 1'b0;
        end else begin
            if (llu_wr) begin
                pending[llu_wr_rd] <= 1'b0;
            end
            if (bus.llu_issue_valid && bus.llu_issue_rd != REG_ZERO) begin
                if (pending[bus.llu_issue_rd]) issue_err_q <= 1'b1;
                pending[bus.llu_issue_rd] <= 1'b1;
            end
        end
    end

    assign bus.issue_err = issue_err_q;
    assign bus.busy_rs1  = !reset && (bus.q_rs1 != REG_ZERO) && pending[bus.q_rs1];
    assign bus.busy_rs2  = !reset && (bus.q_rs2 != REG_ZERO) && pending[bus.q_rs2];
    assign bus.busy_rd   = !reset && (bus.q_rd  != REG_ZERO) && pending[bus.q_rd];

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed scenarios followed by random traffic,
// all checked against a queue/array reference model of the arbiter rules.
module tb_rf_wb_arbiter;
    import rf_wb_arbiter_pkg::*;

    localparam int DEPTH = 4;
    localparam int AW    = RF_AW;
    localparam int DW    = RF_DW;

    // Clock and reset
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    rf_wb_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    rf_wb_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Reference model state
    logic [AW+DW-1:0] exp_q[$];
    bit               pend [2**AW];
    bit               m_err;
    bit               m_xfer;
    int               total;
    int               bad;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Driver: all inputs idle
    task automatic idle();
        reset               = 1'b0;
        bus.wb_valid        = 1'b0;
        bus.wb_rd           = '0;
        bus.wb_data         = '0;
        bus.llu_issue_valid = 1'b0;
        bus.llu_issue_rd    = '0;
        bus.llu_res_valid   = 1'b0;
        bus.llu_res_rd      = '0;
        bus.llu_res_data    = '0;
        bus.q_rs1           = '0;
        bus.q_rs2           = '0;
        bus.q_rd            = '0;
    endtask

    // One cycle: check outputs at negedge against the model, then advance
    // the model across the posedge.
    task automatic step();
        logic          e_ready, e_we, e_busy1, e_busy2, e_busy3, do_pop, do_byp, set_err;
        logic [AW-1:0] e_addr, clr_rd;
        logic [DW-1:0] e_data;
        logic [AW+DW-1:0] hd;
        @(negedge clk);
        do_pop = 1'b0;
        do_byp = 1'b0;
        e_we   = 1'b0;
        e_addr = '0;
        e_data = '0;
        clr_rd = '0;
        e_ready = reset ? 1'b1 : (exp_q.size() < DEPTH);
        m_xfer  = !reset && bus.llu_res_valid && e_ready;
        if (bus.wb_valid) begin
            e_we   = (bus.wb_rd != 0);
            e_addr = bus.wb_rd;
            e_data = bus.wb_data;
        end else if (!reset && exp_q.size() > 0) begin
            hd     = exp_q[0];
            do_pop = 1'b1;
            clr_rd = hd[AW+DW-1:DW];
            e_we   = (clr_rd != 0);
            e_addr = clr_rd;
            e_data = hd[DW-1:0];
        end
`ifdef LLU_BYPASS_EN
        else if (m_xfer) begin
            do_byp = 1'b1;
            clr_rd = bus.llu_res_rd;
            e_we   = (clr_rd != 0);
            e_addr = clr_rd;
            e_data = bus.llu_res_data;
        end
`endif
        e_busy1 = !reset && bus.q_rs1 != 0 && pend[bus.q_rs1];
        e_busy2 = !reset && bus.q_rs2 != 0 && pend[bus.q_rs2];
        e_busy3 = !reset && bus.q_rd  != 0 && pend[bus.q_rd];
        chk("llu_res_ready", DW'(bus.llu_res_ready), DW'(e_ready));
        chk("rf_we",         DW'(bus.rf_we),         DW'(e_we));
        chk("rf_waddr",      DW'(bus.rf_waddr),      DW'(e_addr));
        chk("rf_wdata",      bus.rf_wdata,           e_data);
        chk("busy_rs1",      DW'(bus.busy_rs1),      DW'(e_busy1));
        chk("busy_rs2",      DW'(bus.busy_rs2),      DW'(e_busy2));
        chk("busy_rd",       DW'(bus.busy_rd),       DW'(e_busy3));
        chk("issue_err",     DW'(bus.issue_err),     DW'(m_err));
        set_err = bus.llu_issue_valid && bus.llu_issue_rd != 0 && pend[bus.llu_issue_rd];
        @(posedge clk);
        if (reset) begin
            exp_q.delete();
            foreach (pend[i]) pend[i] = 1'b0;
            m_err = 1'b0;
        end else begin
            if (do_pop) void'(exp_q.pop_front());
            if (do_pop || do_byp) pend[clr_rd] = 1'b0;
            if (m_xfer && !do_byp) exp_q.push_back({bus.llu_res_rd, bus.llu_res_data});
            if (set_err) m_err = 1'b1;
            if (bus.llu_issue_valid && bus.llu_issue_rd != 0) pend[bus.llu_issue_rd] = 1'b1;
        end
        #1;
    endtask

    initial begin
        int sent;
        total = 0;
        bad   = 0;
        m_err = 1'b0;
        foreach (pend[i]) pend[i] = 1'b0;
        idle();
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Reset held: ready high, writeback passes through
        reset = 1'b1; bus.wb_valid = 1'b1; bus.wb_rd = 5'd3; bus.wb_data = 32'h0bad_f00d;
        step();
        idle();

        // Pipeline writeback pass-through, and r0 suppression
        bus.wb_valid = 1'b1; bus.wb_rd = 5'd5; bus.wb_data = 32'hDEADBEEF;
        step();
        bus.wb_rd = 5'd0;
        step();
        idle();

        // Issue r7, result three cycles later, busy until written
        bus.llu_issue_valid = 1'b1; bus.llu_issue_rd = 5'd7; bus.q_rs1 = 5'd7;
        step();
        bus.llu_issue_valid = 1'b0;
        repeat (3) step();
        bus.llu_res_valid = 1'b1; bus.llu_res_rd = 5'd7; bus.llu_res_data = 32'h1234;
        step();
        bus.llu_res_valid = 1'b0;
        repeat (3) step();
        idle();

        // Six writeback cycles while five results arrive; then drain
        sent = 0;
        for (int c = 0; c < 6; c++) begin
            bus.wb_valid = 1'b1; bus.wb_rd = 5'(c + 1); bus.wb_data = $urandom;
            bus.llu_res_valid = (sent < 5); bus.llu_res_rd = 5'(16 + sent);
            bus.llu_res_data = 32'h100 + 32'(sent);
            step();
            if (m_xfer) sent++;
        end
        bus.wb_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            bus.llu_res_valid = (sent < 5); bus.llu_res_rd = 5'(16 + sent);
            bus.llu_res_data = 32'h100 + 32'(sent);
            step();
            if (m_xfer) sent++;
        end
        idle();

        // Double issue of r9, then same-cycle issue r9 with a pop of r9
        bus.llu_issue_valid = 1'b1; bus.llu_issue_rd = 5'd9; bus.q_rs2 = 5'd9;
        step();
        step();
        bus.llu_issue_valid = 1'b0;
        bus.wb_valid = 1'b1; bus.wb_rd = 5'd2; bus.wb_data = 32'h22;
        bus.llu_res_valid = 1'b1; bus.llu_res_rd = 5'd9; bus.llu_res_data = 32'h99;
        step();
        bus.wb_valid = 1'b0; bus.llu_res_valid = 1'b0;
        bus.llu_issue_valid = 1'b1; bus.llu_issue_rd = 5'd9;
        step();
        bus.llu_issue_valid = 1'b0;
        repeat (2) step();
        idle();

        // Reset with three queued results and two pending registers
        bus.llu_issue_valid = 1'b1; bus.llu_issue_rd = 5'd10;
        step();
        bus.llu_issue_rd = 5'd11;
        step();
        bus.llu_issue_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            bus.wb_valid = 1'b1; bus.wb_rd = 5'd1; bus.wb_data = 32'(c);
            bus.llu_res_valid = 1'b1; bus.llu_res_rd = 5'(10 + c); bus.llu_res_data = 32'hA0 + 32'(c);
            step();
        end
        idle();
        reset = 1'b1; bus.q_rs1 = 5'd10; bus.q_rs2 = 5'd11; bus.q_rd = 5'd12;
        step();
        reset = 1'b0;
        repeat (3) step();
        idle();

        // Random traffic over a small register range to force collisions
        for (int c = 0; c < 500; c++) begin
            reset = ($urandom_range(0, 63) == 0);
            bus.wb_valid = ($urandom_range(0, 2) == 0);
            bus.wb_rd = 5'($urandom_range(0, 7));
            bus.wb_data = $urandom;
            bus.llu_issue_valid = ($urandom_range(0, 3) == 0);
            bus.llu_issue_rd = 5'($urandom_range(0, 7));
            if (!(bus.llu_res_valid && !m_xfer)) begin
                bus.llu_res_valid = ($urandom_range(0, 1) == 0);
                bus.llu_res_rd = 5'($urandom_range(0, 7));
                bus.llu_res_data = $urandom;
            end
            bus.q_rs1 = 5'($urandom_range(0, 7));
            bus.q_rs2 = 5'($urandom_range(0, 7));
            bus.q_rd  = 5'($urandom_range(0, 7));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
